// File: rtl/clk_rst_sequencer_if.sv
// ============================================================================
// Module   : clk_rst_sequencer_if
// Brief    : Wizard lock/restart inputs and reset/status outputs of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clk_rst_sequencer_if #(
  parameter int N_DOMAINS = 3
);
  logic                 locked;
  logic                 restart;
  logic                 mmcm_reset;
  logic [N_DOMAINS-1:0] rst_out;
  logic                 ready;
  logic                 fail;
  logic [1:0]           retry_cnt;

  modport master (
    input  locked, restart,
    output mmcm_reset, rst_out, ready, fail, retry_cnt
  );

  modport slave (
    output locked, restart,
    input  mmcm_reset, rst_out, ready, fail, retry_cnt
  );
endinterface

`default_nettype wire

// File: rtl/clk_rst_sequencer.sv
// ============================================================================
// Module   : clk_rst_sequencer
// Brief    : Clock-wizard reset pulse, lock wait/retry, settle and staged
//            per-domain reset release with lock-loss recovery.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_rst_sequencer #(
  parameter int N_DOMAINS     = 3,
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int RELEASE_GAP   = 8,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16
) (
  input  wire logic               clk,
  input  wire logic               reset,
  clk_rst_sequencer_if.master     bus
);

  localparam logic [2:0] C_ST_RST_PULSE = 3'd0;
  localparam logic [2:0] C_ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] C_ST_SETTLE    = 3'd2;
  localparam logic [2:0] C_ST_RELEASE   = 3'd3;
  localparam logic [2:0] C_ST_RUN       = 3'd4;
  localparam logic [2:0] C_ST_FAIL      = 3'd5;

  localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);
  localparam logic [1:0]       C_MAX_RETRY   = 2'(MAX_RETRY);

  logic                 r_lock_s1;
  logic                 r_lock_s2;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_retry;
  logic                 r_mmcm_reset;
  logic [N_DOMAINS-1:0] r_rst_out;
  logic                 r_ready;
  logic                 r_fail;

  logic [2:0]           w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [1:0]           w_retry_nxt;
  logic                 w_release_step;
  logic                 w_mmcm_reset_nxt;
  logic [N_DOMAINS-1:0] w_rst_out_nxt;
  logic                 w_ready_nxt;
  logic                 w_fail_nxt;

  // State, counters, synchronizer and all outputs share one register process.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lock_s1    <= 1'b0;
      r_lock_s2    <= 1'b0;
      r_state      <= C_ST_RST_PULSE;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_mmcm_reset <= 1'b1;
      r_rst_out    <= '1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_lock_s1    <= bus.locked;
      r_lock_s2    <= r_lock_s1;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_retry      <= w_retry_nxt;
      r_mmcm_reset <= w_mmcm_reset_nxt;
      r_rst_out    <= w_rst_out_nxt;
      r_ready      <= w_ready_nxt;
      r_fail       <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + C_CNT_ONE;
    w_retry_nxt = r_retry;
    if (bus.restart) begin
      w_state_nxt = C_ST_RST_PULSE;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        C_ST_RST_PULSE: begin
          if (r_cnt == C_RST_LAST) begin
            w_state_nxt = C_ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end
        end
        C_ST_WAIT_LOCK: begin
          if (r_lock_s2) begin
            w_state_nxt = C_ST_SETTLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_TO_LAST) begin
            w_cnt_nxt = '0;
            if (r_retry == C_MAX_RETRY) begin
              w_state_nxt = C_ST_FAIL;
            end else begin
              w_state_nxt = C_ST_RST_PULSE;
              w_retry_nxt = r_retry + 2'd1;
            end
          end
        end
        C_ST_SETTLE: begin
          if (!r_lock_s2) begin
            w_state_nxt = C_ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_SETTLE_LAST) begin
            w_state_nxt = C_ST_RELEASE;
            w_cnt_nxt   = '0;
          end
        end
        C_ST_RELEASE: begin
          if (!r_lock_s2) begin
            w_state_nxt = C_ST_RST_PULSE;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
          end else if (!r_rst_out[N_DOMAINS-1]) begin
            w_state_nxt = C_ST_RUN;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_GAP_LAST) begin
            w_cnt_nxt = '0;
          end
        end
        C_ST_RUN: begin
          w_cnt_nxt = r_cnt;
          if (!r_lock_s2) begin
            w_state_nxt = C_ST_RST_PULSE;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
          end
        end
        C_ST_FAIL: begin
          w_cnt_nxt = r_cnt;
        end
        default: begin
          w_state_nxt = C_ST_RST_PULSE;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end
      endcase
    end
  end

  // Release clears the lowest still-asserted domain, so rst_out stays a thermometer code.
  always_comb begin
    w_release_step = ((r_state == C_ST_SETTLE)  && (w_state_nxt == C_ST_RELEASE)) ||
                     ((r_state == C_ST_RELEASE) && (w_state_nxt == C_ST_RELEASE) &&
                      (r_cnt == C_GAP_LAST));
    w_mmcm_reset_nxt = (w_state_nxt == C_ST_RST_PULSE) || (w_state_nxt == C_ST_FAIL);
    w_ready_nxt      = (w_state_nxt == C_ST_RUN);
    w_fail_nxt       = (w_state_nxt == C_ST_FAIL);
    case (w_state_nxt)
      C_ST_RELEASE: w_rst_out_nxt = w_release_step ? (r_rst_out << 1) : r_rst_out;
      C_ST_RUN:     w_rst_out_nxt = '0;
      default:      w_rst_out_nxt = '1;
    endcase
  end

  assign bus.mmcm_reset = r_mmcm_reset;
  assign bus.rst_out    = r_rst_out;
  assign bus.ready      = r_ready;
  assign bus.fail       = r_fail;
  assign bus.retry_cnt  = r_retry;

endmodule

`default_nettype wire

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
Power-up and recovery controller for the clock wizard (clk_wiz_0). It drives the wizard's reset input and watches its locked output. Once lock is stable it releases the per-domain resets one at a time, domain 0 first. If lock is not reached in time it retries; if lock is lost later it re-sequences. It sits at the top level between the board clock/reset and every core clock domain.

Parameters:
N_DOMAINS, 3, number of downstream reset outputs (one per wizard clock output)
RST_CYCLES, 4, cycles mmcm_reset is held high per attempt
LOCK_TIMEOUT, 1000, cycles to wait for lock before a retry
SETTLE_CYCLES, 16, consecutive cycles of synchronized lock required before release
RELEASE_GAP, 8, cycles between successive domain releases
MAX_RETRY, 3, timeout retries allowed before FAIL
CNT_W, 16, width of the internal cycle counter; must hold the largest of the cycle parameters

Ports:
clk  input  1  free-running board clock, the same clock that feeds clk_in1 of the wizard
reset  input  1  asynchronous, active-low reset
locked  input  1  wizard lock flag; asynchronous to clk
restart  input  1  single-cycle request to re-run the full sequence
mmcm_reset  output  1  active-high reset to the wizard
rst_out  output  N_DOMAINS  active-high domain resets; bit i maps to clk_out(i+1)
ready  output  1  high when all domains are released and lock is held
fail  output  1  sticky flag: retries exhausted
retry_cnt  output  2  timeout retries used in the current sequence

Behaviour:
- All outputs are registered.
- Reset asserted (low): state=RST_PULSE, counter=0, mmcm_reset=1, rst_out=all 1, ready=0, fail=0, retry_cnt=0. The locked synchronizer clears to 0.
- locked passes through a 2-flop synchronizer to give locked_s. The FSM only ever uses locked_s.
- RST_PULSE:
  - mmcm_reset=1 and rst_out=all 1.
  - After RST_CYCLES edges, go to WAIT_LOCK with counter=0 and mmcm_reset=0.
- WAIT_LOCK:
  - On locked_s=1, go to SETTLE with counter=0.
  - Otherwise, when counter reaches LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRY, go to FAIL;
    - else increment retry_cnt and go to RST_PULSE.
- SETTLE:
  - Counts consecutive edges with locked_s=1.
  - If locked_s=0 at any edge, return to WAIT_LOCK with counter=0. The timeout restarts and retry_cnt is unchanged.
  - After SETTLE_CYCLES edges, go to RELEASE and clear rst_out[0] on the same edge.
- RELEASE:
  - rst_out[i] clears exactly RELEASE_GAP edges after rst_out[i-1].
  - One edge after the last bit clears, go to RUN with ready=1.
  - Resets never re-assert during release except through the lock-loss rule below.
- Timing rule: let T be the edge at which the FSM first sees locked_s=1 in WAIT_LOCK.
  - rst_out[i] clears at T+SETTLE_CYCLES+i*RELEASE_GAP.
  - ready rises at T+SETTLE_CYCLES+(N_DOMAINS-1)*RELEASE_GAP+1.
- Lock loss in RELEASE or RUN (locked_s=0):
  - Next edge: rst_out=all 1, ready=0, retry_cnt=0, go to RST_PULSE.
  - Loss of lock is never ignored and is never counted as a retry.
- FAIL:
  - mmcm_reset=1, rst_out=all 1, ready=0, fail=1.
  - Only restart or reset leaves FAIL.
- restart=1 in any state has top priority, including over a timeout or lock loss on the same edge.
  - Next edge: go to RST_PULSE, counter=0, retry_cnt=0, fail=0, rst_out=all 1, ready=0.
- Reset asserted mid-sequence, including mid-RELEASE: all outputs return to reset values immediately, without waiting for a clock edge.
- Counter width: CNT_W must hold the largest of LOCK_TIMEOUT, SETTLE_CYCLES and RELEASE_GAP.
- retry_cnt saturates at MAX_RETRY. MAX_RETRY must be ≤3.
- Invariant: ready=1 implies rst_out=0 and mmcm_reset=0.
- Invariant: rst_out[i]=0 implies rst_out[j]=0 for all j<i.

Test Plan:
- Nominal (defaults): release reset; locked rises 50 cycles later.
  -> mmcm_reset high for exactly 4 cycles.
  -> rst_out[0], [1], [2] clear at T+16, T+24, T+32.
  -> ready=1 at T+33; retry_cnt=0.
- Timeout retry (LOCK_TIMEOUT=20): hold locked=0 for the first attempt, raise it during the second.
  -> a second 4-cycle mmcm_reset pulse.
  -> retry_cnt=1.
  -> normal release after the second attempt locks.
- Fail (LOCK_TIMEOUT=20, MAX_RETRY=3): locked stuck at 0.
  -> exactly 4 mmcm_reset pulses, then fail=1 with mmcm_reset held at 1.
  -> restart pulse: fail=0 and a new sequence starts.
- Settle glitch: locked drops for 1 cycle at T+10 during SETTLE.
  -> no domain released until 16 consecutive lock cycles after the recovery.
  -> retry_cnt unchanged.
- Lock loss in RUN: drop locked while ready=1.
  -> within 3 edges of the input change: rst_out=111 and ready=0.
  -> new mmcm_reset pulse follows; re-release follows once lock returns.
- Reset mid-RELEASE: assert reset after rst_out=110.
  -> immediately rst_out=111, mmcm_reset=1, ready=0.
  -> full sequence restarts on deassertion.
